// File: rtl/vga_background_fetch.sv
// ---------------------------------------------------------------------------
// vga_background_fetch
//
// Per-scanline fetch sequencer for the two-shifter background datapath.
// At the start of horizontal blanking it decides whether the next line needs
// new background pixels. If it does, it reads two 32-bit words (32 px at
// 2 bpp) from background memory and hands each word to the pixel generator
// with a one-cycle load strobe. Vertical pixel scaling is handled by
// repeating a background row for bg_v_size+1 lines. A fetch still running
// when the active region begins is abandoned and flagged as an underrun.
//
// Ports:
//   clk, reset         clock and synchronous active-high reset
//   h_counter          current horizontal position
//   v_counter          current line
//   h_active_start     first active column; deadline for a running fetch
//   h_active_end       first blanking column; fetch trigger point
//   v_active_start     first active line
//   v_active_end       first inactive line
//   bg_base_addr       word address of background row 0
//   bg_v_size          lines per background row minus 1
//   mem_req/mem_addr   memory read request and word address
//   mem_ack/mem_data   read completion and read data (valid with mem_ack)
//   bg_pixels          pixel word presented to both shifters
//   bg_pixels_load_0/1 one-cycle load strobes for shifter 0 / shifter 1
//   busy               fetch in progress
//   underrun           sticky late-fetch flag
//   underrun_clear     clears underrun (a simultaneous new underrun wins)
// ---------------------------------------------------------------------------
module vga_background_fetch #(
    parameter int ADDR_W = 16,
    parameter int ROW_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [9:0]        h_counter,
    input  logic [9:0]        v_counter,
    input  logic [9:0]        h_active_start,
    input  logic [9:0]        h_active_end,
    input  logic [9:0]        v_active_start,
    input  logic [9:0]        v_active_end,
    input  logic [ADDR_W-1:0] bg_base_addr,
    input  logic [5:0]        bg_v_size,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [31:0]       mem_data,
    output logic [31:0]       bg_pixels,
    output logic              bg_pixels_load_0,
    output logic              bg_pixels_load_1,
    output logic              busy,
    output logic              underrun,
    input  logic              underrun_clear
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ0 = 2'd1,
        REQ1 = 2'd2
    } state_t;

    state_t            state;
    logic [ROW_W-1:0]  row_index;
    logic [5:0]        line_count;

    logic [9:0]        next_line;
    logic              trigger;
    logic              line_active;
    logic              first_line;
    logic              row_advance;
    logic              fetch;
    logic              deadline;
    logic [ROW_W-1:0]  fetch_row;
    logic [ADDR_W-1:0] first_addr;
    logic [ADDR_W-1:0] second_addr;

    // Decide at the trigger point what the next line needs. The shifters
    // rotate back to their original contents after 32 shifts, so a line that
    // repeats the previous background row needs no refetch; only the first
    // active line and a row change start a memory fetch.
    always_comb begin
        next_line   = v_counter + 10'd1;
        trigger     = (state == IDLE) && (h_counter == h_active_end);
        line_active = (next_line >= v_active_start) && (next_line < v_active_end);
        first_line  = (next_line == v_active_start);
        row_advance = (line_count == bg_v_size);
        fetch       = trigger && line_active && (first_line || row_advance);
        deadline    = (state != IDLE) && (h_counter == h_active_start);

        // Row used by a fetch starting this cycle: the row state is updated
        // on the same edge, so the address is built from the new row.
        fetch_row = '0;
        if (!first_line) begin
            fetch_row = row_index + ROW_W'(1);
        end

        // Each background row occupies two consecutive memory words.
        first_addr  = bg_base_addr + (ADDR_W'(fetch_row) << 1);
        second_addr = bg_base_addr + (ADDR_W'(row_index) << 1) + ADDR_W'(1);
    end

    // Row tracking, request sequencing and the underrun flag. The deadline
    // check takes priority over an acknowledge arriving on the same edge, so
    // an abandoned fetch never produces another load strobe; a strobe that
    // was already registered still shows for its one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            mem_req          <= 1'b0;
            mem_addr         <= '0;
            bg_pixels        <= '0;
            bg_pixels_load_0 <= 1'b0;
            bg_pixels_load_1 <= 1'b0;
            busy             <= 1'b0;
            underrun         <= 1'b0;
            row_index        <= '0;
            line_count       <= '0;
        end else begin
            bg_pixels_load_0 <= 1'b0;
            bg_pixels_load_1 <= 1'b0;

            if (underrun_clear) begin
                underrun <= 1'b0;
            end

            if (trigger && line_active) begin
                if (first_line) begin
                    row_index  <= '0;
                    line_count <= '0;
                end else if (row_advance) begin
                    row_index  <= row_index + ROW_W'(1);
                    line_count <= '0;
                end else begin
                    line_count <= line_count + 6'd1;
                end
            end

            case (state)
                IDLE: begin
                    if (fetch) begin
                        state    <= REQ0;
                        mem_req  <= 1'b1;
                        mem_addr <= first_addr;
                        busy     <= 1'b1;
                    end
                end

                REQ0: begin
                    if (deadline) begin
                        state    <= IDLE;
                        mem_req  <= 1'b0;
                        busy     <= 1'b0;
                        underrun <= 1'b1;
                    end else if (mem_ack) begin
                        state            <= REQ1;
                        bg_pixels        <= mem_data;
                        bg_pixels_load_0 <= 1'b1;
                        mem_addr         <= second_addr;
                    end
                end

                REQ1: begin
                    if (deadline) begin
                        state    <= IDLE;
                        mem_req  <= 1'b0;
                        busy     <= 1'b0;
                        underrun <= 1'b1;
                    end else if (mem_ack) begin
                        state            <= IDLE;
                        bg_pixels        <= mem_data;
                        bg_pixels_load_1 <= 1'b1;
                        mem_req          <= 1'b0;
                        busy             <= 1'b0;
                    end
                end

                default: begin
                    state   <= IDLE;
                    mem_req <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vga_background_fetch.sv
// ---------------------------------------------------------------------------
// tb_vga_background_fetch
//
// Self-checking bench for vga_background_fetch. A 40-column line is used:
// blanking starts at column 32 and the next active region starts at column 8,
// giving 16 cycles between trigger and deadline. A memory responder answers
// each request after a chosen latency (and throws in stray acks while idle).
// A line-level model derives from the row/scaling rules whether a fetch
// happens, which addresses are read, which strobes fire and whether the
// fetch misses the deadline; a monitor tallies what the DUT actually did.
// ---------------------------------------------------------------------------
module tb_vga_background_fetch;

    localparam int ADDR_W = 16;
    localparam int ROW_W  = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic [9:0]        h_counter;
    logic [9:0]        v_counter;
    logic [9:0]        h_active_start;
    logic [9:0]        h_active_end;
    logic [9:0]        v_active_start;
    logic [9:0]        v_active_end;
    logic [ADDR_W-1:0] bg_base_addr;
    logic [5:0]        bg_v_size;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [31:0]       mem_data;
    logic [31:0]       bg_pixels;
    logic              bg_pixels_load_0;
    logic              bg_pixels_load_1;
    logic              busy;
    logic              underrun;
    logic              underrun_clear;

    int tests    = 0;
    int failures = 0;

    // Responder controls, written by the main sequence
    int          lat0      = 0;
    int          lat1      = 0;
    logic [31:0] d0        = 32'h0;
    logic [31:0] d1        = 32'h0;
    logic        force_ack = 1'b0;

    // Monitor tallies, written only by the monitor
    int          req_rises   = 0;
    int          load0_total = 0;
    int          load1_total = 0;
    int          busy_total  = 0;
    logic [31:0] load0_data  = 32'h0;
    logic [31:0] load1_data  = 32'h0;
    logic [15:0] addr_q[$];

    // Reference model state
    int          m_row   = 0;
    int          m_lc    = 0;
    logic        m_under = 1'b0;
    logic [31:0] m_pix   = 32'h0;

    vga_background_fetch #(
        .ADDR_W(ADDR_W),
        .ROW_W (ROW_W)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .h_counter       (h_counter),
        .v_counter       (v_counter),
        .h_active_start  (h_active_start),
        .h_active_end    (h_active_end),
        .v_active_start  (v_active_start),
        .v_active_end    (v_active_end),
        .bg_base_addr    (bg_base_addr),
        .bg_v_size       (bg_v_size),
        .mem_req         (mem_req),
        .mem_addr        (mem_addr),
        .mem_ack         (mem_ack),
        .mem_data        (mem_data),
        .bg_pixels       (bg_pixels),
        .bg_pixels_load_0(bg_pixels_load_0),
        .bg_pixels_load_1(bg_pixels_load_1),
        .busy            (busy),
        .underrun        (underrun),
        .underrun_clear  (underrun_clear)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        tests++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_mem_req"},  32'(mem_req), 32'h0);
        checkOutput({tag, "_mem_addr"}, 32'(mem_addr), 32'h0);
        checkOutput({tag, "_pixels"},   bg_pixels, 32'h0);
        checkOutput({tag, "_load0"},    32'(bg_pixels_load_0), 32'h0);
        checkOutput({tag, "_load1"},    32'(bg_pixels_load_1), 32'h0);
        checkOutput({tag, "_busy"},     32'(busy), 32'h0);
        checkOutput({tag, "_underrun"}, 32'(underrun), 32'h0);
    endtask

    // Memory responder: acks the first request word after lat0 idle cycles
    // and the second after lat1, returning d0/d1. Runs just after the falling
    // edge so controls written on that edge are already visible.
    initial begin
        int cnt;
        int idx;
        cnt      = 0;
        idx      = 0;
        mem_ack  = 1'b0;
        mem_data = 32'h0;
        forever begin
            @(negedge clk);
            #1;
            mem_ack = 1'b0;
            if (force_ack) begin
                mem_ack  = 1'b1;
                mem_data = 32'hDEADBEEF;
                cnt      = 0;
                idx      = 0;
            end else if (mem_req === 1'b1) begin
                if (cnt == ((idx == 0) ? lat0 : lat1)) begin
                    mem_ack  = 1'b1;
                    mem_data = (idx == 0) ? d0 : d1;
                    cnt      = 0;
                    idx      = 1;
                end else begin
                    cnt++;
                end
            end else begin
                cnt = 0;
                idx = 0;
                if ($urandom_range(0, 7) == 0) begin
                    mem_ack  = 1'b1;
                    mem_data = $urandom;
                end
            end
        end
    end

    // Monitor: tallies request rises, presented addresses, strobes and busy cycles
    initial begin
        logic        prev_req;
        logic [15:0] prev_addr;
        prev_req  = 1'b0;
        prev_addr = 16'h0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_req === 1'b1 && (!prev_req || mem_addr != prev_addr)) begin
                addr_q.push_back(mem_addr);
            end
            if (mem_req === 1'b1 && !prev_req) begin
                req_rises++;
            end
            if (bg_pixels_load_0 === 1'b1) begin
                load0_total++;
                load0_data = bg_pixels;
            end
            if (bg_pixels_load_1 === 1'b1) begin
                load1_total++;
                load1_data = bg_pixels;
            end
            if (busy === 1'b1) begin
                busy_total++;
            end
            prev_req  = (mem_req === 1'b1);
            prev_addr = mem_addr;
        end
    end

    // One line period starting at the trigger column. clr_pos: 0 none,
    // 1 clear on the deadline cycle, 2 clear well after the deadline.
    task automatic applyStimulus(input logic [9:0] v_i, input int l0, input int l1,
                                 input int clr_pos, input logic [31:0] dd0,
                                 input logic [31:0] dd1);
        logic [9:0]  n;
        logic [15:0] exp_addr;
        bit          do_fetch;
        bit          ld0;
        bit          ld1;
        bit          new_u;
        int          exp_busy;
        int          rs0;
        int          l0s;
        int          l1s;
        int          bs0;
        int          aq0;

        lat0 = l0;
        lat1 = l1;
        d0   = dd0;
        d1   = dd1;

        n        = v_i + 10'd1;
        do_fetch = 1'b0;
        if (n >= v_active_start && n < v_active_end) begin
            if (n == v_active_start) begin
                m_row    = 0;
                m_lc     = 0;
                do_fetch = 1'b1;
            end else if (m_lc == int'(bg_v_size)) begin
                m_row    = (m_row + 1) % 256;
                m_lc     = 0;
                do_fetch = 1'b1;
            end else begin
                m_lc = (m_lc + 1) % 64;
            end
        end
        exp_addr = 16'(int'(bg_base_addr) + m_row * 2);

        // Trigger at edge 0, deadline at edge 16: word k lands at edge
        // 1+lat0 (and 2+lat0+lat1) and counts only if it lands before 16.
        ld0      = do_fetch && (l0 + 1 <= 15);
        ld1      = do_fetch && (l0 + l1 + 2 <= 15);
        new_u    = do_fetch && !ld1;
        exp_busy = !do_fetch ? 0 : (ld1 ? (2 + l0 + l1) : 16);
        if (clr_pos == 1) begin
            m_under = new_u;
        end else begin
            m_under = m_under | new_u;
        end
        if (ld1) begin
            m_pix = dd1;
        end else if (ld0) begin
            m_pix = dd0;
        end

        rs0 = req_rises;
        l0s = load0_total;
        l1s = load1_total;
        bs0 = busy_total;
        aq0 = addr_q.size();

        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (k == 31) begin
                checkOutput("req_rises", 32'(req_rises - rs0), 32'(do_fetch));
                checkOutput("load0_count", 32'(load0_total - l0s), 32'(ld0));
                checkOutput("load1_count", 32'(load1_total - l1s), 32'(ld1));
                checkOutput("busy_cycles", 32'(busy_total - bs0), 32'(exp_busy));
                checkOutput("addr_count", 32'(addr_q.size() - aq0),
                            32'(do_fetch ? (1 + int'(ld0)) : 0));
                if (do_fetch && addr_q.size() > aq0) begin
                    checkOutput("addr_word0", 32'(addr_q[aq0]), 32'(exp_addr));
                end
                if (ld0 && addr_q.size() > aq0 + 1) begin
                    checkOutput("addr_word1", 32'(addr_q[aq0 + 1]), 32'(16'(exp_addr + 16'd1)));
                end
                if (ld0) begin
                    checkOutput("load0_data", load0_data, dd0);
                end
                if (ld1) begin
                    checkOutput("load1_data", load1_data, dd1);
                end
                checkOutput("underrun", 32'(underrun), 32'(m_under));
                checkOutput("bg_pixels", bg_pixels, m_pix);
                checkOutput("req_idle", 32'(mem_req), 32'h0);
                if (clr_pos == 2) begin
                    m_under = 1'b0;
                end
            end
            h_counter      = 10'((32 + k) % 40);
            v_counter      = (k < 8) ? v_i : v_i + 10'd1;
            underrun_clear = (clr_pos == 1 && k == 16) || (clr_pos == 2 && k == 34);
        end
    endtask

    // Reset asserted while the second word is outstanding, then late acks
    task automatic resetMidFetch();
        int l0s;
        int l1s;
        lat0 = 0;
        lat1 = 30;
        d0   = 32'h12345678;
        d1   = 32'h9ABCDEF0;
        l0s  = load0_total;
        l1s  = load1_total;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (k == 3) begin
                checkResetState("reset_mid");
            end
            if (k == 6) begin
                checkResetState("late_ack");
                checkOutput("reset_load0_count", 32'(load0_total - l0s), 32'h1);
                checkOutput("reset_load1_count", 32'(load1_total - l1s), 32'h0);
            end
            h_counter      = 10'((32 + k) % 40);
            v_counter      = (k < 8) ? 10'd1 : 10'd2;
            underrun_clear = 1'b0;
            reset          = (k == 2 || k == 3);
            force_ack      = (k == 3 || k == 4);
        end
        m_row   = 0;
        m_lc    = 0;
        m_under = 1'b0;
        m_pix   = 32'h0;
    endtask

    function automatic int pickLatency();
        if ($urandom_range(0, 4) == 0) begin
            return int'($urandom_range(10, 17));
        end
        return int'($urandom_range(0, 4));
    endfunction

    initial begin
        reset          = 1'b1;
        h_counter      = 10'd0;
        v_counter      = 10'd0;
        h_active_start = 10'd8;
        h_active_end   = 10'd32;
        v_active_start = 10'd2;
        v_active_end   = 10'd9;
        bg_base_addr   = 16'h0100;
        bg_v_size      = 6'd0;
        underrun_clear = 1'b0;

        repeat (3) @(negedge clk);
        checkResetState("reset");
        reset = 1'b0;

        // Basic fetch on the first active line
        applyStimulus(10'd1, 0, 0, 0, 32'hAAAA5555, 32'h0F0F0F0F);

        // Vertical scaling: rows repeat three times
        bg_base_addr = 16'h0200;
        bg_v_size    = 6'd2;
        for (int v = 1; v <= 7; v++) begin
            applyStimulus(10'(v), 1, 1, 0, $urandom, $urandom);
        end

        // Next line is the first inactive line
        applyStimulus(10'd8, 0, 0, 0, $urandom, $urandom);

        // Slow memory: deadline hit before the first word, clear afterwards
        applyStimulus(10'd1, 20, 0, 2, $urandom, $urandom);
        applyStimulus(10'd2, 0, 0, 0, $urandom, $urandom);

        // Second word late; clear on the deadline cycle loses to the set
        applyStimulus(10'd1, 3, 15, 1, $urandom, $urandom);
        applyStimulus(10'd2, 0, 0, 1, $urandom, $urandom);

        // Address wrap past the top of memory
        bg_base_addr = 16'hFFFF;
        bg_v_size    = 6'd0;
        applyStimulus(10'd1, 0, 2, 0, $urandom, $urandom);

        // Next-line computation wraps at 10 bits
        v_active_start = 10'd0;
        applyStimulus(10'd1023, 1, 0, 0, $urandom, $urandom);
        v_active_start = 10'd2;

        resetMidFetch();

        // Randomized frames
        for (int f = 0; f < 6; f++) begin
            bg_base_addr = ($urandom_range(0, 3) == 0) ? 16'hFFFE : 16'($urandom);
            bg_v_size    = 6'($urandom_range(0, 3));
            for (int v = 0; v < 12; v++) begin
                applyStimulus(10'(v), pickLatency(), pickLatency(),
                              int'($urandom_range(0, 2)), $urandom, $urandom);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] time limit");
    end

endmodule
